ram_cmd_arbiter: RTL and testbench



---
 rtl/ram_arb_pkg.sv | 17 +
 rtl/rr_arbiter_2.sv | 28 ++
 rtl/ram_cmd_arbiter.sv | 157 +++++++++++++++
 tb/tb_ram_cmd_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM command arbiter.
// FSM states and RAM command opcodes.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    WAIT_RD
  } state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter.
// Grant is one-hot; history moves only on accept.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic r_last;

  // contested requests go to the index not granted last
  always_comb begin
    grant = req;
    if (req == 2'b11)
      grant = r_last ? 2'b01 : 2'b10;
  end

  // remember the winner of each accepted request
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_last <= 1'b1;
    else if (accept && (grant != 2'b00))
      r_last <= grant[1];
  end

endmodule

// File: rtl/ram_cmd_arbiter.sv
// Serializes two requesters onto the RAM command stream.
// Address/data command pairs never interleave.
module ram_cmd_arbiter
  import ram_arb_pkg::*;
#(
  parameter int MEM_DEPTH  = 256,
  parameter int RD_TIMEOUT = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [1:0]                          req_valid,
  output logic [1:0]                          req_ready,
  input  logic [1:0]                          req_we,
  input  logic [1:0][$clog2(MEM_DEPTH)-1:0]   req_addr,
  input  logic [1:0][$clog2(MEM_DEPTH)-1:0]   req_wdata,
  output logic [1:0]                          rsp_valid,
  output logic [$clog2(MEM_DEPTH)-1:0]        rsp_data,
  output logic                                rsp_err,
  output logic [$clog2(MEM_DEPTH)+1:0]        rx_data,
  output logic                                rx_valid,
  input  logic [$clog2(MEM_DEPTH)-1:0]        tx_data,
  input  logic                                tx_valid
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = $clog2(RD_TIMEOUT + 1);

  state_t          r_state;
  state_t          w_state_n;
  logic            r_owner;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [AW-1:0]   r_wdata;
  logic [CW-1:0]   r_cnt;
  logic            w_hit;
  logic [1:0]      w_grant;
  logic            w_gidx;
  logic            w_accept;
  logic            w_rx_valid_n;
  logic [AW+1:0]   w_rx_data_n;
  logic [1:0]      w_rsp_valid_n;
  logic [AW-1:0]   w_rsp_data_n;
  logic            w_rsp_err_n;

  rr_arbiter_2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid),
    .accept (w_accept),
    .grant  (w_grant)
  );

  assign w_gidx    = w_grant[1];
  assign w_accept  = rst_n && (r_state == IDLE) && (req_valid != 2'b00);
  assign req_ready = w_accept ? w_grant : 2'b00;
  assign w_hit     = (r_cnt == CW'(RD_TIMEOUT - 1));

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_state_n;
  end

  // next-state logic
  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      IDLE:    if (req_valid != 2'b00) w_state_n = ADDR;
      ADDR:    w_state_n = DATA;
      DATA:    w_state_n = r_we ? IDLE : WAIT_RD;
      WAIT_RD: if (tx_valid || w_hit) w_state_n = IDLE;
    endcase
  end

  // capture the accepted transaction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_owner <= w_gidx;
      r_we    <= req_we[w_gidx];
      r_addr  <= req_addr[w_gidx];
      r_wdata <= req_wdata[w_gidx];
    end
  end

  // read timeout counter, cleared while issuing the data command
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (r_state == DATA)
      r_cnt <= '0;
    else if ((r_state == WAIT_RD) && !tx_valid)
      r_cnt <= r_cnt + 1'b1;
  end

  // next values of the registered outputs
  always_comb begin
    w_rx_valid_n  = 1'b0;
    w_rx_data_n   = '0;
    w_rsp_valid_n = 2'b00;
    w_rsp_data_n  = '0;
    w_rsp_err_n   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (req_valid != 2'b00) begin
          w_rx_valid_n = 1'b1;
          w_rx_data_n  = {req_we[w_gidx] ? CMD_WR_ADDR : CMD_RD_ADDR,
                          req_addr[w_gidx]};
        end
      end
      ADDR: begin
        w_rx_valid_n = 1'b1;
        w_rx_data_n  = r_we ? {CMD_WR_DATA, r_wdata}
                            : {CMD_RD_DATA, AW'(0)};
      end
      DATA: begin
        w_rx_valid_n = 1'b0;
      end
      WAIT_RD: begin
        if (tx_valid) begin
          w_rsp_valid_n[r_owner] = 1'b1;
          w_rsp_data_n           = tx_data;
        end else if (w_hit) begin
          w_rsp_valid_n[r_owner] = 1'b1;
          w_rsp_err_n            = 1'b1;
        end
      end
    endcase
  end

  // output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      rsp_valid <= 2'b00;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rx_valid  <= w_rx_valid_n;
      rx_data   <= w_rx_data_n;
      rsp_valid <= w_rsp_valid_n;
      rsp_data  <= w_rsp_data_n;
      rsp_err   <= w_rsp_err_n;
    end
  end

  logic w_unused;
  assign w_unused = ^r_addr;

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Bench for ram_cmd_arbiter: vector table, alternation
// sequence, and randomized traffic against a timeline model.
module tb_ram_cmd_arbiter;

  localparam int AW = 8;
  localparam int TO = 4;
  localparam int NR = 400;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [1:0]           req_we;
  logic [1:0][AW-1:0]   req_addr;
  logic [1:0][AW-1:0]   req_wdata;
  logic [1:0]           rsp_valid;
  logic [AW-1:0]        rsp_data;
  logic                 rsp_err;
  logic [AW+1:0]        rx_data;
  logic                 rx_valid;
  logic [AW-1:0]        tx_data;
  logic                 tx_valid;

  ram_cmd_arbiter #(.MEM_DEPTH(256), .RD_TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit       rst;
    bit [1:0] rv;
    bit [1:0] we;
    bit [7:0] a0, w0, a1, w1;
    bit       txv;
    bit [7:0] txd;
    bit [1:0] rdy;
    bit       rxv;
    bit [9:0] rxd;
    bit [1:0] rspv;
    bit [7:0] rspd;
    bit       err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic add(input bit rst, input bit [1:0] rv, input bit [1:0] we,
                     input bit [7:0] a0, input bit [7:0] w0,
                     input bit [7:0] a1, input bit [7:0] w1,
                     input bit txv, input bit [7:0] txd,
                     input bit [1:0] rdy, input bit rxv, input bit [9:0] rxd,
                     input bit [1:0] rspv, input bit [7:0] rspd,
                     input bit err);
    vec_t v;
    v.rst = rst; v.rv = rv; v.we = we;
    v.a0 = a0; v.w0 = w0; v.a1 = a1; v.w1 = w1;
    v.txv = txv; v.txd = txd;
    v.rdy = rdy; v.rxv = rxv; v.rxd = rxd;
    v.rspv = rspv; v.rspd = rspd; v.err = err;
    tbl.push_back(v);
  endtask

  task automatic drive(input bit rst, input bit [1:0] rv, input bit [1:0] we,
                       input bit [7:0] a0, input bit [7:0] w0,
                       input bit [7:0] a1, input bit [7:0] w1,
                       input bit txv, input bit [7:0] txd);
    rst_n        = rst;
    req_valid    = rv;
    req_we       = we;
    req_addr[0]  = a0;
    req_wdata[0] = w0;
    req_addr[1]  = a1;
    req_wdata[1] = w1;
    tx_valid     = txv;
    tx_data      = txd;
  endtask

  task automatic check_out(input string tag, input bit [1:0] rdy,
                           input bit rxv, input bit [9:0] rxd,
                           input bit [1:0] rspv, input bit [7:0] rspd,
                           input bit err);
    chk({tag, "/ready"}, 32'(req_ready), 32'(rdy));
    chk({tag, "/rx_valid"}, 32'(rx_valid), 32'(rxv));
    if (rxv) chk({tag, "/rx_data"}, 32'(rx_data), 32'(rxd));
    chk({tag, "/rsp_valid"}, 32'(rsp_valid), 32'(rspv));
    if (rspv != 2'b00) begin
      chk({tag, "/rsp_data"}, 32'(rsp_data), 32'(rspd));
      chk({tag, "/rsp_err"}, 32'(rsp_err), 32'(err));
    end
  endtask

  bit       e_rxv  [0:NR+15];
  bit [9:0] e_rxd  [0:NR+15];
  bit [1:0] e_rspv [0:NR+15];
  bit [7:0] e_rspd [0:NR+15];
  bit       e_err  [0:NR+15];
  bit       s_txv  [0:NR+15];
  bit [7:0] s_txd  [0:NR+15];

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // directed vectors
    add(0,0,0,0,0,0,0,0,0,         0,0,0,0,0,0);
    add(1,1,1,'h10,'hA5,0,0,0,0,   1,0,0,0,0,0);
    add(1,0,0,0,0,0,0,0,0,         0,1,'h010,0,0,0);
    add(1,0,0,0,0,0,0,0,0,         0,1,'h1A5,0,0,0);
    add(1,2,0,0,0,'h10,0,0,0,      2,0,0,0,0,0);
    add(1,0,0,0,0,0,0,0,0,         0,1,'h210,0,0,0);
    add(1,0,0,0,0,0,0,0,0,         0,1,'h300,0,0,0);
    add(1,0,0,0,0,0,0,1,'hA5,      0,0,0,0,0,0);
    add(1,0,0,0,0,0,0,1,'h77,      0,0,0,2,'hA5,0);
    add(1,1,0,'h33,0,0,0,0,0,      1,0,0,0,0,0);
    add(1,0,0,0,0,0,0,0,0,         0,1,'h233,0,0,0);
    add(1,0,0,0,0,0,0,0,0,         0,1,'h300,0,0,0);
    add(1,0,0,0,0,0,0,0,0,         0,0,0,0,0,0);
    add(1,0,0,0,0,0,0,0,0,         0,0,0,0,0,0);
    add(1,0,0,0,0,0,0,0,0,         0,0,0,0,0,0);
    add(1,0,0,0,0,0,0,0,0,         0,0,0,0,0,0);
    add(1,2,2,0,0,'h44,'h55,0,0,   2,0,0,1,0,1);
    add(1,0,0,0,0,0,0,0,0,         0,1,'h044,0,0,0);
    add(1,0,0,0,0,0,0,0,0,         0,1,'h155,0,0,0);
    add(1,1,0,'h20,0,0,0,0,0,      1,0,0,0,0,0);
    add(1,0,0,0,0,0,0,0,0,         0,1,'h220,0,0,0);
    add(0,0,0,0,0,0,0,0,0,         0,1,'h300,0,0,0);
    add(1,3,0,'h66,0,'h77,0,0,0,   1,0,0,0,0,0);
    add(1,0,0,0,0,0,0,0,0,         0,1,'h266,0,0,0);
    add(1,0,0,0,0,0,0,0,0,         0,1,'h300,0,0,0);
    add(1,0,0,0,0,0,0,1,'h12,      0,0,0,0,0,0);
    add(1,3,0,'h66,0,'h77,0,0,0,   2,0,0,1,'h12,0);
    add(1,0,0,0,0,0,0,0,0,         0,1,'h277,0,0,0);
    add(1,0,0,0,0,0,0,0,0,         0,1,'h300,0,0,0);
    add(1,0,0,0,0,0,0,1,'h34,      0,0,0,0,0,0);
    add(1,0,0,0,0,0,0,1,'h56,      0,0,0,2,'h34,0);
    add(1,0,0,0,0,0,0,0,0,         0,0,0,0,0,0);

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      drive(tbl[i].rst, tbl[i].rv, tbl[i].we, tbl[i].a0, tbl[i].w0,
            tbl[i].a1, tbl[i].w1, tbl[i].txv, tbl[i].txd);
      @(negedge clk);
      check_out($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].rxv,
                tbl[i].rxd, tbl[i].rspv, tbl[i].rspd, tbl[i].err);
    end

    // both requesters held: grants alternate, pairs stay intact
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 12; k++) begin
      int       own;
      bit [1:0] rdy;
      bit       rxv;
      bit [9:0] rxd;
      bit [7:0] ad [2];
      bit [7:0] wd [2];
      ad[0] = 8'h5A; wd[0] = 8'hC3;
      ad[1] = 8'h6B; wd[1] = 8'h3C;
      own = (k / 3) % 2;
      rdy = (k % 3 == 0) ? 2'(1 << own) : 2'b00;
      rxv = (k % 3 != 0) && (k >= 1);
      rxd = (k % 3 == 1) ? {2'b00, ad[own]} : {2'b01, wd[own]};
      @(posedge clk); #1;
      drive(1, 3, 3, ad[0], wd[0], ad[1], wd[1], 0, 0);
      @(negedge clk);
      check_out($sformatf("alt%0d", k), rdy, rxv, rxd, 0, 0, 0);
    end

    // randomized traffic against a transaction timeline
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    foreach (e_rxv[i]) begin
      e_rxv[i] = 0; e_rxd[i] = 0; e_rspv[i] = 0;
      e_rspd[i] = 0; e_err[i] = 0; s_txv[i] = 0; s_txd[i] = 0;
    end
    begin
      int free_at = 0;
      int wlo = -1;
      int whi = -2;
      bit lastg = 1;
      for (int c = 0; c < NR; c++) begin
        bit [1:0] rv, we, rdy;
        bit [7:0] ad [2];
        bit [7:0] wd [2];
        bit       txv;
        bit [7:0] txd;
        int       g, d;
        rv = 2'($urandom);
        we = 2'($urandom);
        ad[0] = 8'($urandom); ad[1] = 8'($urandom);
        wd[0] = 8'($urandom); wd[1] = 8'($urandom);
        if (c >= NR - 12) rv = 2'b00;
        rdy = 2'b00;
        if (c >= free_at && rv != 2'b00) begin
          if (rv == 2'b11) g = lastg ? 0 : 1;
          else g = (rv == 2'b10) ? 1 : 0;
          lastg = g[0];
          rdy = 2'(1 << g);
          e_rxv[c+1] = 1;
          e_rxd[c+1] = {we[g] ? 2'b00 : 2'b10, ad[g]};
          e_rxv[c+2] = 1;
          e_rxd[c+2] = we[g] ? {2'b01, wd[g]} : {2'b11, 8'h00};
          if (we[g]) free_at = c + 3;
          else begin
            d = $urandom_range(0, TO);
            wlo = c + 3;
            if (d < TO) begin
              s_txv[c+3+d]  = 1;
              s_txd[c+3+d]  = 8'($urandom);
              e_rspv[c+4+d] = rdy;
              e_rspd[c+4+d] = s_txd[c+3+d];
              e_err[c+4+d]  = 0;
              free_at = c + 4 + d;
              whi = c + 3 + d;
            end else begin
              e_rspv[c+3+TO] = rdy;
              e_rspd[c+3+TO] = 0;
              e_err[c+3+TO]  = 1;
              free_at = c + 3 + TO;
              whi = c + 2 + TO;
            end
          end
        end
        txv = 0;
        txd = 8'($urandom);
        if (s_txv[c]) begin
          txv = 1;
          txd = s_txd[c];
        end else if (!(c >= wlo && c <= whi))
          txv = ($urandom_range(0, 3) == 0);
        @(posedge clk); #1;
        drive(1, rv, we, ad[0], wd[0], ad[1], wd[1], txv, txd);
        @(negedge clk);
        check_out($sformatf("rnd%0d", c), rdy, e_rxv[c], e_rxd[c],
                  e_rspv[c], e_rspd[c], e_err[c]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
